// File: rtl/freq_det_pkg.sv
// Shared types and constants for the freq_det measurement sequencer and register file.
// The optional ARM timeout is enabled with FREQ_DET_TIMEOUT_EN.
package freq_det_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/freq_det_gate_timer.sv
// Loadable down-counter; done_c flags the last enabled cycle of a loaded window.
// Used for the gate window and, with FREQ_DET_TIMEOUT_EN, for the ARM timeout.
module freq_det_gate_timer #(
  parameter int unsigned W = 32
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = en && (cnt_q == W'(1));

endmodule

// File: rtl/freq_det_ctrl.sv
// Measurement sequencer: align to first edge, count edges over an exact gate, hold result.
// Define FREQ_DET_TIMEOUT_EN to end an ARM phase with a no_signal result after N cycles.
module freq_det_ctrl
  import freq_det_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_continuous,
  input  logic [CNT_W-1:0] cfg_gate_cycles,
  input  logic             edge_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow,
  output logic             no_signal,
  output logic             irq
);

  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(CNT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gate_len_q;
  logic             cont_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;

  logic             start_ok_c;
  logic [CNT_W-1:0] cfg_len_c;
  logic             align_c;
  logic             gate_done_c;
  logic             timeout_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             ovf_nxt_c;

  assign start_ok_c = cfg_start && !cfg_stop;
  assign cfg_len_c  = (cfg_gate_cycles == '0) ? CNT_W'(1) : cfg_gate_cycles;
  assign align_c    = (state_q == ST_ARM) && (state_d == ST_GATE);

  // Saturating edge count; overflow marks that the counter reached its ceiling
  assign cnt_nxt_c = (edge_pulse && (edge_cnt_q != SAT_MAX)) ? edge_cnt_q + CNT_W'(1)
                                                               : edge_cnt_q;
  assign ovf_nxt_c = ovf_q || (cnt_nxt_c == SAT_MAX);

  freq_det_gate_timer #(.W(CNT_W)) u_gate_timer (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .load     (align_c),
    .load_val (gate_len_q),
    .en       (state_q == ST_GATE),
    .done_c   (gate_done_c)
  );

`ifdef FREQ_DET_TIMEOUT_EN
  logic             arm_load_c;
  logic [CNT_W-1:0] arm_len_c;

  // Armed from IDLE uses the length being latched; re-arm from HOLD uses the stored one
  assign arm_load_c = (state_q != ST_ARM) && (state_d == ST_ARM);
  assign arm_len_c  = (state_q == ST_IDLE) ? cfg_len_c : gate_len_q;

  freq_det_gate_timer #(.W(CNT_W)) u_arm_timer (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .load     (arm_load_c),
    .load_val (arm_len_c),
    .en       (state_q == ST_ARM),
    .done_c   (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok_c) state_d = ST_ARM;
      ST_ARM: begin
        if (cfg_stop)        state_d = ST_IDLE;
        else if (edge_pulse) state_d = ST_GATE;
        else if (timeout_c)  state_d = ST_HOLD;
      end
      ST_GATE: begin
        if (cfg_stop)         state_d = ST_IDLE;
        else if (gate_done_c) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (result_ready) state_d = (cont_q && !cfg_stop) ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      gate_len_q   <= '0;
      cont_q       <= 1'b0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      no_signal    <= 1'b0;
      irq          <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      irq     <= 1'b0;

      if ((state_q == ST_IDLE) && start_ok_c) begin
        gate_len_q <= cfg_len_c;
        cont_q     <= cfg_continuous;
      end else if (cfg_stop && (state_q != ST_IDLE)) begin
        cont_q <= 1'b0;
      end

      if (align_c) begin
        edge_cnt_q <= '0;
        ovf_q      <= 1'b0;
        no_signal  <= 1'b0;
      end else if (state_q == ST_GATE) begin
        edge_cnt_q <= cnt_nxt_c;
        ovf_q      <= ovf_nxt_c;
      end

      if ((state_q == ST_GATE) && (state_d == ST_HOLD)) begin
        result       <= cnt_nxt_c;
        overflow     <= ovf_nxt_c;
        result_valid <= 1'b1;
        irq          <= 1'b1;
      end else if ((state_q == ST_ARM) && (state_d == ST_HOLD)) begin
        result       <= '0;
        overflow     <= 1'b0;
        no_signal    <= 1'b1;
        result_valid <= 1'b1;
        irq          <= 1'b1;
      end else if ((state_q == ST_HOLD) && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
